// File: rtl/gcd_engine.sv
`default_nettype none
// ============================================================================
// Module   : gcd_engine
// Purpose  : Multi-cycle GCD of two signed operands. Input and output each
//            use a valid/ready handshake. The algorithm is chosen at
//            elaboration: ALGO=0 is subtractive Euclid, ALGO=1 is binary Stein.
//            The engine reports how many iterations changed its state.
// Ports    : clock    - rising-edge clock
//            resetN   - asynchronous active-low reset
//            inValid  - operands a/b are present
//            inReady  - engine can accept operands (IDLE and out of reset)
//            a, b     - signed two's complement operands, WIDTH bits
//            flush    - synchronous abort back to IDLE
//            outValid - result is available (DONE)
//            outReady - consumer accepts the result
//            result   - unsigned GCD of |a| and |b|
//            steps    - state-updating RUN iterations, saturating
//            busy     - engine is in RUN or DONE
// Revision : 1.0 - initial release
// ============================================================================
module gcd_engine #(
  parameter int WIDTH  = 64,
  parameter int ALGO   = 0,
  parameter int STEP_W = 16
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              inValid,
  output logic              inReady,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              flush,
  output logic              outValid,
  input  logic              outReady,
  output logic [WIDTH-1:0]  result,
  output logic [STEP_W-1:0] steps,
  output logic              busy
);

  // k counts common factors of two; it can reach at most WIDTH-1.
  localparam int c_KW = $clog2(WIDTH) + 1;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  x_q, x_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic [c_KW-1:0]   k_q, k_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [STEP_W-1:0] steps_q, steps_d;

  logic [WIDTH-1:0]  a_abs, b_abs;
  logic [WIDTH-1:0]  x_step, y_step;
  logic              k_inc;
  logic              term;
  logic [WIDTH-1:0]  gcd_base;

  // Unsigned negation: the most negative input maps onto 2^(WIDTH-1) exactly.
  assign a_abs = a[WIDTH-1] ? ((~a) + WIDTH'(1)) : a;
  assign b_abs = b[WIDTH-1] ? ((~b) + WIDTH'(1)) : b;

  assign term     = (x_q == '0) || (y_q == '0) || (x_q == y_q);
  assign gcd_base = (x_q == '0) ? y_q : x_q;

  // One iteration of the selected algorithm, assuming no termination.
  generate
    if (ALGO == 0) begin : g_euclid
      always_comb begin
        x_step = x_q;
        y_step = y_q;
        k_inc  = 1'b0;
        if (x_q > y_q) begin
          x_step = x_q - y_q;
        end else begin
          y_step = y_q - x_q;
        end
      end
    end else begin : g_stein
      always_comb begin
        x_step = x_q;
        y_step = y_q;
        k_inc  = 1'b0;
        if (!x_q[0] && !y_q[0]) begin
          x_step = x_q >> 1;
          y_step = y_q >> 1;
          k_inc  = 1'b1;
        end else if (!x_q[0]) begin
          x_step = x_q >> 1;
        end else if (!y_q[0]) begin
          y_step = y_q >> 1;
        end else if (x_q > y_q) begin
          x_step = (x_q - y_q) >> 1;
        end else begin
          y_step = (y_q - x_q) >> 1;
        end
      end
    end
  endgenerate

  // State and datapath registers.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q  <= c_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      k_q      <= '0;
      result_q <= '0;
      steps_q  <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      k_q      <= k_d;
      result_q <= result_d;
      steps_q  <= steps_d;
    end
  end

  // Next-state logic. flush overrides everything and leaves the datapath,
  // including result and steps, untouched.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    k_d      = k_q;
    result_d = result_q;
    steps_d  = steps_q;
    if (flush) begin
      state_d = c_IDLE;
    end else begin
      case (state_q)
        c_IDLE: begin
          if (inValid) begin
            state_d = c_RUN;
            x_d     = a_abs;
            y_d     = b_abs;
            k_d     = '0;
            steps_d = '0;
          end
        end
        c_RUN: begin
          if (term) begin
            result_d = gcd_base << k_q;
            state_d  = c_DONE;
          end else begin
            x_d     = x_step;
            y_d     = y_step;
            k_d     = k_q + c_KW'(k_inc);
            steps_d = (&steps_q) ? steps_q : (steps_q + STEP_W'(1));
          end
        end
        c_DONE: begin
          if (outReady) begin
            state_d = c_IDLE;
          end
        end
        default: begin
          state_d = c_IDLE;
        end
      endcase
    end
  end

  // Outputs. inReady is gated by resetN so it drops as soon as reset asserts.
  always_comb begin
    inReady  = (state_q == c_IDLE) && resetN;
    outValid = (state_q == c_DONE);
    busy     = (state_q != c_IDLE);
    result   = result_q;
    steps    = steps_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_gcd_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_gcd_engine
// Purpose  : Directed self-checking bench for gcd_engine. Five instances
//            cover both algorithms, 64- and 8-bit widths and a 4-bit step
//            counter. Inputs change and outputs are sampled on negedges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcd_engine;

  logic        clk;
  logic        resetN;
  logic        flush;
  logic        outReady;
  logic [4:0]  iv;
  logic [63:0] a64, b64;
  logic [7:0]  a8, b8;

  logic [4:0]  ir, ov, bs;
  logic [63:0] res0, res1;
  logic [7:0]  res2, res3, res4;
  logic [15:0] st0, st1, st2, st3;
  logic [3:0]  st4;

  int checks = 0;
  int errors = 0;

  assign a8 = a64[7:0];
  assign b8 = b64[7:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  gcd_engine #(.WIDTH(64), .ALGO(0), .STEP_W(16)) u0 (
    .clock(clk), .resetN(resetN), .inValid(iv[0]), .inReady(ir[0]),
    .a(a64), .b(b64), .flush(flush), .outValid(ov[0]), .outReady(outReady),
    .result(res0), .steps(st0), .busy(bs[0]));

  gcd_engine #(.WIDTH(64), .ALGO(1), .STEP_W(16)) u1 (
    .clock(clk), .resetN(resetN), .inValid(iv[1]), .inReady(ir[1]),
    .a(a64), .b(b64), .flush(flush), .outValid(ov[1]), .outReady(outReady),
    .result(res1), .steps(st1), .busy(bs[1]));

  gcd_engine #(.WIDTH(8), .ALGO(0), .STEP_W(16)) u2 (
    .clock(clk), .resetN(resetN), .inValid(iv[2]), .inReady(ir[2]),
    .a(a8), .b(b8), .flush(flush), .outValid(ov[2]), .outReady(outReady),
    .result(res2), .steps(st2), .busy(bs[2]));

  gcd_engine #(.WIDTH(8), .ALGO(1), .STEP_W(16)) u3 (
    .clock(clk), .resetN(resetN), .inValid(iv[3]), .inReady(ir[3]),
    .a(a8), .b(b8), .flush(flush), .outValid(ov[3]), .outReady(outReady),
    .result(res3), .steps(st3), .busy(bs[3]));

  gcd_engine #(.WIDTH(8), .ALGO(0), .STEP_W(4)) u4 (
    .clock(clk), .resetN(resetN), .inValid(iv[4]), .inReady(ir[4]),
    .a(a8), .b(b8), .flush(flush), .outValid(ov[4]), .outReady(outReady),
    .result(res4), .steps(st4), .busy(bs[4]));

  function automatic logic [63:0] get_res(input int idx);
    case (idx)
      0:       return res0;
      1:       return res1;
      2:       return {56'd0, res2};
      3:       return {56'd0, res3};
      default: return {56'd0, res4};
    endcase
  endfunction

  function automatic logic [15:0] get_st(input int idx);
    case (idx)
      0:       return st0;
      1:       return st1;
      2:       return st2;
      3:       return st3;
      default: return {12'd0, st4};
    endcase
  endfunction

  // Present one operand pair, wait for acceptance, then count clock edges
  // after the accept edge until outValid. Leaves the engine in DONE.
  task automatic do_op(input int idx, input logic [63:0] av, input logic [63:0] bv,
                       output logic [63:0] r, output logic [15:0] s, output int lat);
    int n;
    @(negedge clk);
    a64 = av;
    b64 = bv;
    iv[idx] = 1'b1;
    n = 0;
    while (!ir[idx] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ir[idx]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout u%0d: inReady=%b required 1", idx, ir[idx]);
    end
    @(negedge clk);
    iv[idx] = 1'b0;
    lat = 0;
    while (!ov[idx] && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (!ov[idx]) begin
      checks++;
      errors++;
      $display("FAIL done_timeout u%0d: outValid=%b required 1", idx, ov[idx]);
    end
    r = get_res(idx);
    s = get_st(idx);
  endtask

  task automatic consume();
    @(negedge clk);
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (ir !== 5'b0) begin errors++; $display("FAIL reset_inReady: got %b required 00000", ir); end
    checks++; if (ov !== 5'b0) begin errors++; $display("FAIL reset_outValid: got %b required 00000", ov); end
    checks++; if (bs !== 5'b0) begin errors++; $display("FAIL reset_busy: got %b required 00000", bs); end
    checks++; if (res0 !== 64'd0) begin errors++; $display("FAIL reset_result: got %0d required 0", res0); end
    checks++; if (st0 !== 16'd0) begin errors++; $display("FAIL reset_steps: got %0d required 0", st0); end
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    checks++; if (ir !== 5'b11111) begin errors++; $display("FAIL release_inReady: got %b required 11111", ir); end
  endtask

  task automatic test_basic_euclid();
    logic [63:0] r;
    logic [15:0] s;
    int lat;
    do_op(0, 64'd12, 64'd18, r, s, lat);
    checks++; if (r !== 64'd6) begin errors++; $display("FAIL euclid_12_18_result: got %0d required 6", r); end
    checks++; if (s !== 16'd2) begin errors++; $display("FAIL euclid_12_18_steps: got %0d required 2", s); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL euclid_12_18_latency: got %0d required 3", lat); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ov[0] !== 1'b1 || res0 !== 64'd6 || st0 !== 16'd2) begin
        errors++;
        $display("FAIL euclid_hold_%0d: outValid=%b result=%0d steps=%0d required 1/6/2", i, ov[0], res0, st0);
      end
    end
    consume();
    checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL euclid_consume_outValid: got %b required 0", ov[0]); end
    checks++; if (res0 !== 64'd6 || ir[0] !== 1'b1) begin
      errors++; $display("FAIL euclid_after_consume: result=%0d inReady=%b required 6/1", res0, ir[0]);
    end
  endtask

  task automatic test_basic_stein();
    logic [63:0] r;
    logic [15:0] s;
    int lat;
    do_op(1, 64'd12, 64'd18, r, s, lat);
    checks++; if (r !== 64'd6) begin errors++; $display("FAIL stein_12_18_result: got %0d required 6", r); end
    checks++; if (s !== 16'd3) begin errors++; $display("FAIL stein_12_18_steps: got %0d required 3", s); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL stein_12_18_latency: got %0d required 4", lat); end
    consume();
    do_op(1, 64'hFFFF_FFFF_FFFF_FFD0, 64'd180, r, s, lat);
    checks++; if (r !== 64'd12) begin errors++; $display("FAIL stein_m48_180_result: got %0d required 12", r); end
    checks++; if (s !== 16'd7) begin errors++; $display("FAIL stein_m48_180_steps: got %0d required 7", s); end
    consume();
  endtask

  task automatic test_extremes();
    logic [63:0] av [4] = '{64'h00, 64'h00, 64'h80, 64'h80};
    logic [63:0] bv [4] = '{64'h00, 64'hF9, 64'h80, 64'h60};
    logic [63:0] er [4] = '{64'd0, 64'd7, 64'd128, 64'd32};
    logic [15:0] es0 [4] = '{16'd0, 16'd0, 16'd0, 16'd3};
    logic [15:0] es1 [4] = '{16'd0, 16'd0, 16'd0, 16'd8};
    logic [63:0] r;
    logic [15:0] s;
    logic [15:0] es;
    int lat;
    for (int u = 2; u <= 3; u++) begin
      for (int i = 0; i < 4; i++) begin
        do_op(u, av[i], bv[i], r, s, lat);
        es = (u == 2) ? es0[i] : es1[i];
        checks++;
        if (r !== er[i]) begin
          errors++; $display("FAIL extreme_u%0d_v%0d_result: got %0d required %0d", u, i, r, er[i]);
        end
        checks++;
        if (s !== es) begin
          errors++; $display("FAIL extreme_u%0d_v%0d_steps: got %0d required %0d", u, i, s, es);
        end
        consume();
      end
    end
  endtask

  task automatic test_handshake();
    logic [63:0] r;
    logic [15:0] s;
    int lat;
    int n;
    do_op(2, 64'd12, 64'd18, r, s, lat);
    @(negedge clk);
    outReady = 1'b1;
    a64 = 64'd5;
    b64 = 64'd10;
    iv[2] = 1'b1;
    checks++; if (ir[2] !== 1'b0) begin errors++; $display("FAIL hs_inReady_in_done: got %b required 0", ir[2]); end
    @(negedge clk);
    outReady = 1'b0;
    checks++; if (bs[2] !== 1'b0 || ov[2] !== 1'b0 || ir[2] !== 1'b1) begin
      errors++; $display("FAIL hs_idle_after_done: busy=%b outValid=%b inReady=%b required 0/0/1", bs[2], ov[2], ir[2]);
    end
    @(negedge clk);
    iv[2] = 1'b0;
    checks++; if (bs[2] !== 1'b1) begin errors++; $display("FAIL hs_accept_next_idle: busy=%b required 1", bs[2]); end
    n = 0;
    while (!ov[2] && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++; if (ov[2] !== 1'b1 || res2 !== 8'd5) begin
      errors++; $display("FAIL hs_second_result: outValid=%b result=%0d required 1/5", ov[2], res2);
    end
    consume();
  endtask

  task automatic test_flush();
    logic [63:0] r;
    logic [15:0] s;
    logic [15:0] s_at_flush;
    logic        seen;
    int lat;
    // flush mid-RUN: engine idles, steps frozen, no outValid ever.
    @(negedge clk);
    a64 = 64'd1000000;
    b64 = 64'd1;
    iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (3) @(negedge clk);
    flush = 1'b1;
    s_at_flush = st0;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (bs[0] !== 1'b0 || st0 !== s_at_flush) begin
      errors++; $display("FAIL flush_run: busy=%b steps=%0d required 0/%0d", bs[0], st0, s_at_flush);
    end
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (ov[0]) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_outValid: seen=%b required 0", seen); end
    // flush and outReady together in DONE.
    do_op(3, 64'd12, 64'd18, r, s, lat);
    @(negedge clk);
    flush = 1'b1;
    outReady = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    outReady = 1'b0;
    checks++; if (bs[3] !== 1'b0 || ov[3] !== 1'b0 || ir[3] !== 1'b1) begin
      errors++; $display("FAIL flush_done_state: busy=%b outValid=%b inReady=%b required 0/0/1", bs[3], ov[3], ir[3]);
    end
    checks++; if (res3 !== 8'd6 || st3 !== 16'd3) begin
      errors++; $display("FAIL flush_done_hold: result=%0d steps=%0d required 6/3", res3, st3);
    end
    do_op(3, 64'd9, 64'd6, r, s, lat);
    checks++; if (r !== 64'd3 || s !== 16'd2) begin
      errors++; $display("FAIL flush_then_new: result=%0d steps=%0d required 3/2", r, s);
    end
    consume();
  endtask

  task automatic test_saturation();
    logic [63:0] r;
    logic [15:0] s;
    int lat;
    do_op(4, 64'd100, 64'd1, r, s, lat);
    checks++; if (s !== 16'd15) begin errors++; $display("FAIL sat_steps: got %0d required 15", s); end
    checks++; if (r !== 64'd1) begin errors++; $display("FAIL sat_result: got %0d required 1", r); end
    checks++; if (lat !== 100) begin errors++; $display("FAIL sat_latency: got %0d required 100", lat); end
    consume();
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    a64 = 64'd1000000;
    b64 = 64'd1;
    iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    checks++; if (bs[0] !== 1'b1) begin errors++; $display("FAIL rst_run_busy: got %b required 1", bs[0]); end
    repeat (4) @(negedge clk);
    #2;
    resetN = 1'b0;
    #1;
    checks++; if (bs[0] !== 1'b0 || ov[0] !== 1'b0 || ir[0] !== 1'b0) begin
      errors++; $display("FAIL rst_async_ctrl: busy=%b outValid=%b inReady=%b required 0/0/0", bs[0], ov[0], ir[0]);
    end
    checks++; if (res0 !== 64'd0 || st0 !== 16'd0) begin
      errors++; $display("FAIL rst_async_data: result=%0d steps=%0d required 0/0", res0, st0);
    end
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    checks++; if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
      errors++; $display("FAIL rst_release: inReady=%b outValid=%b required 1/0", ir[0], ov[0]);
    end
  endtask

  initial begin
    resetN   = 1'b0;
    flush    = 1'b0;
    outReady = 1'b0;
    iv       = 5'b0;
    a64      = 64'd0;
    b64      = 64'd0;
    test_reset();
    test_basic_euclid();
    test_basic_stein();
    test_extremes();
    test_handshake();
    test_flush();
    test_saturation();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gcd_engine.md
Name: gcd_engine

Overview:
- Parametrised multi-cycle GCD unit of signed operands with valid/ready handshakes on both input and output.
- Algorithm is selectable at elaboration: subtractive Euclid or binary (Stein).
- Reports a step count alongside the result.
- Sits behind a request producer and in front of a result consumer in the arithmetic test designs; replaces the fixed-width, handshake-less GCD.

Parameters:
- WIDTH, 64, operand width in bits (signed two's complement inputs); minimum 2.
- ALGO, 0, 0 = subtractive Euclid, 1 = binary Stein.
- STEP_W, 16, width of the step counter output.

Ports:
- clock  in  1  rising-edge clock.
- resetN  in  1  asynchronous active-low reset.
- inValid  in  1  operands a/b present.
- inReady  out  1  engine can accept operands.
- a  in  WIDTH  signed operand A.
- b  in  WIDTH  signed operand B.
- flush  in  1  synchronous abort, returns the engine to IDLE.
- outValid  out  1  result available.
- outReady  in  1  consumer accepts result.
- result  out  WIDTH  unsigned GCD of |a| and |b|.
- steps  out  STEP_W  RUN iterations that performed a state update; saturates at all-ones.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (resetN low, asynchronous): state = IDLE; inReady = 0 while resetN is low, 1 after release; outValid = 0; result = 0; steps = 0; busy = 0; internal x, y, k = 0.
- States are IDLE, RUN, DONE.
- inReady = (state == IDLE) and resetN high. Input is never accepted in RUN or DONE, including the cycle in which outReady is taken.
- IDLE:
  - On inValid && inReady: x <= |a|, y <= |b|, k <= 0, steps <= 0; go to RUN.
  - Absolute values are computed in WIDTH-bit unsigned, so a = -2^(WIDTH-1) yields 2^(WIDTH-1) exactly.
- RUN, one evaluation per cycle:
  - Termination check first: if x == 0, y == 0, or x == y, capture result <= ((x == 0) ? y : x) << k and go to DONE. This cycle does not increment steps.
  - ALGO = 0: if x > y then x <= x - y, else y <= y - x.
  - ALGO = 1, checked in priority order:
    - both even: x >>= 1, y >>= 1, k++.
    - x even: x >>= 1.
    - y even: y >>= 1.
    - both odd: if x > y then x <= (x - y) >> 1, else y <= (y - x) >> 1.
  - k is used only when ALGO = 1 (it stays 0 otherwise); the shifted result never exceeds 2^(WIDTH-1).
  - Every non-terminating RUN cycle increments steps, saturating.
- Special inputs:
  - a = b = 0 gives result 0.
  - One operand zero gives |other|.
  - Every input terminates; no infinite loop on zero operands.
- DONE:
  - outValid = 1; result and steps are held stable until handshake.
  - On outReady: outValid <= 0, go to IDLE.
  - result and steps keep their last values until the next load.
- flush (synchronous, any state): state <= IDLE, outValid <= 0; result and steps are unchanged.
  - flush has priority over inValid and outReady in the same cycle.
  - A flushed computation never produces outValid.
- Latency: accept cycle + (steps + 1) RUN cycles, then outValid. Minimum is 2 cycles from accept to outValid.
- busy = (state != IDLE).
- Comparisons and subtractions are unsigned WIDTH-bit. Operands x, y are never negative after load.

Test Plan:
- Reset mid-RUN:
  - Stimulus: load a=1000000, b=1 (ALGO=0), then drop resetN 5 cycles later.
  - Response: outputs go to 0 immediately, without a clock edge; after release inReady=1, no stale outValid.
- Basic, ALGO=0:
  - Stimulus: a=12, b=18.
  - Response: result=6, steps=2, outValid 4 cycles after accept edge counting the accept cycle; held for 3 cycles with outReady=0, then cleared the cycle after outReady=1.
- Basic, ALGO=1:
  - Stimulus: a=12, b=18.
  - Response: result=6, steps=3.
  - Stimulus: a=-48, b=180.
  - Response: result=12.
- Zero and extreme operands, WIDTH=8:
  - a=0, b=0 gives result 0, steps 0.
  - a=0, b=-7 gives result 7.
  - a=-128, b=-128 gives result 128.
  - a=-128, b=96 gives result 32.
  - Check for both ALGO values.
- Handshake rules:
  - inValid held high in DONE with outReady=1: inReady=0 that cycle; the next operands are accepted only in the following IDLE cycle.
  - flush and outReady asserted together in DONE: IDLE, no double consumption.
- Saturation:
  - Stimulus: STEP_W=4, ALGO=0, a=100, b=1 (99 subtract steps).
  - Response: steps=15, result=1.
